ex_div_unit: RTL and testbench

//   Multi-cycle RV32M divider in the EX stage; consumes operands/func3 from the ID/EX register.

---
 rtl/ex_div_unit.sv | 199 +++++++++++++++++++
 tb/tb_ex_div_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ex_div_unit.sv
// RV32M divide/remainder unit for the EX stage: radix-2 restoring divider
// that stalls the front of the pipeline until its result is ready.
module ex_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            FLUSH,
  input  logic [1:0]      OP,
  input  logic [XLEN-1:0] OPERAND_A,
  input  logic [XLEN-1:0] OPERAND_B,
  output logic            STALL,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_MAX = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t          state_r;
  logic            sel_rem_r;
  logic            neg_q_r;
  logic            neg_rem_r;
  logic [CW-1:0]   cnt_r;
  logic [XLEN-1:0] q_r;
  logic [XLEN-1:0] b_r;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] result_r;
  logic            busy_r;
  logic            done_r;

  logic            is_signed_s;
  logic [XLEN-1:0] a_mag_s;
  logic [XLEN-1:0] b_mag_s;
  logic            div_zero_s;
  logic            ovf_s;
  logic [XLEN:0]   rem_sh_s;
  logic            ge_s;
  logic [XLEN-1:0] rem_nxt_s;
  logic [XLEN-1:0] q_fix_s;
  logic [XLEN-1:0] rem_fix_s;

  function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] x);
    return (~x) + ONE;
  endfunction

  // Operand conditioning and special-case detection for the accept edge
  always_comb begin
    is_signed_s = ~OP[0];
    a_mag_s     = OPERAND_A;
    b_mag_s     = OPERAND_B;
    if (is_signed_s && OPERAND_A[XLEN-1]) begin
      a_mag_s = neg2c(OPERAND_A);
    end else begin
      a_mag_s = OPERAND_A;
    end
    if (is_signed_s && OPERAND_B[XLEN-1]) begin
      b_mag_s = neg2c(OPERAND_B);
    end else begin
      b_mag_s = OPERAND_B;
    end
    div_zero_s = (OPERAND_B == '0);
    ovf_s      = is_signed_s && (OPERAND_A == MIN_NEG) && (OPERAND_B == '1);
  end

  // One restoring step; the remainder stays below |B| so XLEN bits hold it between steps
  always_comb begin
    rem_sh_s  = {rem_r, q_r[XLEN-1]};
    ge_s      = (rem_sh_s >= {1'b0, b_r});
    rem_nxt_s = rem_sh_s[XLEN-1:0];
    if (ge_s) begin
      rem_nxt_s = rem_sh_s[XLEN-1:0] - b_r;
    end else begin
      rem_nxt_s = rem_sh_s[XLEN-1:0];
    end
  end

  // Sign restoration applied in FIX
  always_comb begin
    q_fix_s   = q_r;
    rem_fix_s = rem_r;
    if (neg_q_r) begin
      q_fix_s = neg2c(q_r);
    end else begin
      q_fix_s = q_r;
    end
    if (neg_rem_r) begin
      rem_fix_s = neg2c(rem_r);
    end else begin
      rem_fix_s = rem_r;
    end
  end

  // Divider control FSM with datapath and registered status outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      sel_rem_r <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      cnt_r     <= '0;
      q_r       <= '0;
      b_r       <= '0;
      rem_r     <= '0;
      result_r  <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else if (FLUSH) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (START) begin
            sel_rem_r <= OP[1];
            q_r       <= a_mag_s;
            b_r       <= b_mag_s;
            rem_r     <= '0;
            neg_q_r   <= is_signed_s && (OPERAND_A[XLEN-1] ^ OPERAND_B[XLEN-1]);
            neg_rem_r <= is_signed_s && OPERAND_A[XLEN-1];
            if (div_zero_s) begin
              result_r <= OP[1] ? OPERAND_A : '1;
              state_r  <= ST_DONE;
              busy_r   <= 1'b0;
              done_r   <= 1'b1;
            end else if (ovf_s) begin
              result_r <= OP[1] ? '0 : MIN_NEG;
              state_r  <= ST_DONE;
              busy_r   <= 1'b0;
              done_r   <= 1'b1;
            end else begin
              cnt_r   <= CNT_MAX;
              state_r <= ST_CALC;
              busy_r  <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_CALC: begin
          q_r   <= {q_r[XLEN-2:0], ge_s};
          rem_r <= rem_nxt_s;
          if (cnt_r == '0) begin
            state_r <= ST_FIX;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_FIX: begin
          result_r <= sel_rem_r ? rem_fix_s : q_fix_s;
          state_r  <= ST_DONE;
          busy_r   <= 1'b0;
          done_r   <= 1'b1;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // STALL must cover the accept cycle itself, so it is decoded combinationally
  always_comb begin
    STALL = 1'b0;
    case (state_r)
      ST_IDLE: STALL = START & ~FLUSH;
      ST_CALC: STALL = 1'b1;
      ST_FIX:  STALL = 1'b1;
      ST_DONE: STALL = 1'b0;
      default: STALL = 1'b0;
    endcase
  end

  assign BUSY   = busy_r;
  assign DONE   = done_r;
  assign RESULT = result_r;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: hand-computed quotients/remainders, latency,
// stall/busy behaviour, flush and reset mid-operation.
module tb_ex_div_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        FLUSH;
  logic [1:0]  OP;
  logic [31:0] OPERAND_A;
  logic [31:0] OPERAND_B;
  logic        STALL;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  ex_div_unit #(.XLEN(32)) dut (
    .CLK(CLK), .RST(RST), .START(START), .FLUSH(FLUSH), .OP(OP),
    .OPERAND_A(OPERAND_A), .OPERAND_B(OPERAND_B),
    .STALL(STALL), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // lat = edges after the accept edge until DONE is seen; -1 on timeout
  task automatic wait_done(output int lat, output int stalls, output logic busy_seen);
    lat = -1;
    stalls = 0;
    busy_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (DONE) begin
        lat = i;
        break;
      end
      if (STALL) stalls++;
      if (BUSY) busy_seen = 1'b1;
    end
  endtask

  task automatic do_div(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input logic exp_busy);
    int lat;
    int stalls;
    logic busy_seen;
    START = 1'b1;
    OP = op;
    OPERAND_A = a;
    OPERAND_B = b;
    #1 chk({tag, "_stall_acc"}, 32'(STALL), 32'd1);
    wait_done(lat, stalls, busy_seen);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, RESULT, exp_res);
    chk({tag, "_stalls"}, 32'(stalls), 32'(exp_lat));
    chk({tag, "_busy"}, 32'(busy_seen), 32'(exp_busy));
    chk({tag, "_stall_done"}, 32'(STALL), 32'd0);
    START = 1'b0;
    @(negedge CLK);
    chk({tag, "_pulse"}, 32'(DONE), 32'd0);
  endtask

  initial begin
    int lat;
    int stalls;
    logic busy_seen;
    RST = 1'b1;
    START = 1'b0;
    FLUSH = 1'b0;
    OP = 2'b00;
    OPERAND_A = 32'd0;
    OPERAND_B = 32'd0;
    repeat (2) @(negedge CLK);
    chk("rst_stall", 32'(STALL), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_result", RESULT, 32'd0);
    RST = 1'b0;

    do_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b1);
    do_div("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b1);
    do_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b1);
    do_div("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b1);
    do_div("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b1);
    do_div("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 1'b0);
    do_div("rem_5_0", OP_REM, 32'd5, 32'd0, 32'd5, 0, 1'b0);
    do_div("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b0);
    do_div("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1'b0);
    do_div("divu_ovf_ops", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 1'b1);
    do_div("remu_100_7b", OP_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b1);

    // Flush in the middle of CALC; FLUSH also held against START in IDLE
    START = 1'b1;
    OP = OP_DIVU;
    OPERAND_A = 32'd1000;
    OPERAND_B = 32'd3;
    repeat (11) @(negedge CLK);
    chk("flush_pre_busy", 32'(BUSY), 32'd1);
    FLUSH = 1'b1;
    @(negedge CLK);
    chk("flush_busy", 32'(BUSY), 32'd0);
    chk("flush_done", 32'(DONE), 32'd0);
    chk("flush_result", RESULT, 32'd2);
    #1 chk("flush_win_stall", 32'(STALL), 32'd0);
    @(negedge CLK);
    chk("flush_win_busy", 32'(BUSY), 32'd0);
    chk("flush_win_done", 32'(DONE), 32'd0);
    FLUSH = 1'b0;
    do_div("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 33, 1'b1);

    // Reset in the middle of CALC
    START = 1'b1;
    OP = OP_DIVU;
    OPERAND_A = 32'd100;
    OPERAND_B = 32'd7;
    repeat (6) @(negedge CLK);
    chk("rst_mid_pre_busy", 32'(BUSY), 32'd1);
    RST = 1'b1;
    START = 1'b0;
    @(negedge CLK);
    chk("rst_mid_stall", 32'(STALL), 32'd0);
    chk("rst_mid_busy", 32'(BUSY), 32'd0);
    chk("rst_mid_done", 32'(DONE), 32'd0);
    chk("rst_mid_result", RESULT, 32'd0);
    RST = 1'b0;

    // Back-to-back with START held: DONE cycle ignores START, next IDLE accepts
    START = 1'b1;
    OP = OP_DIVU;
    OPERAND_A = 32'd1;
    OPERAND_B = 32'd1;
    wait_done(lat, stalls, busy_seen);
    chk("b2b1_lat", 32'(lat), 32'd33);
    chk("b2b1_res", RESULT, 32'd1);
    OP = OP_REMU;
    OPERAND_A = 32'd10;
    OPERAND_B = 32'd4;
    #1 chk("b2b_stall_done", 32'(STALL), 32'd0);
    @(negedge CLK);
    chk("b2b_gap_done", 32'(DONE), 32'd0);
    chk("b2b_gap_stall", 32'(STALL), 32'd1);
    wait_done(lat, stalls, busy_seen);
    chk("b2b2_lat", 32'(lat), 32'd33);
    chk("b2b2_res", RESULT, 32'd2);
    START = 1'b0;
    @(negedge CLK);
    chk("b2b2_pulse", 32'(DONE), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
